// File: rtl/fila_entrada.sv
// -----------------------------------------------------------------------------
// fila_entrada
//
// Input FIFO that sits between an external word source and the CPU Rx
// register. It is a circular buffer in first-word-fall-through mode: the
// oldest stored word is always on `entrada`, and the CPU pops it by
// asserting `carga` on the same edge that loads Rx.
//
// Parameters
//   LARGURA       data word width (matches the CPU entrada bus), default 5
//   PROFUNDIDADE  number of stored words, power of two in 2..16, default 4
//
// Ports
//   clock       in   single clock, all state updates on the rising edge
//   reset_n     in   asynchronous active-low reset
//   dado_in     in   [LARGURA-1:0] word offered by the source
//   dado_valid  in   source offers dado_in this cycle
//   dado_ready  out  FIFO accepts a word this cycle (= not cheio)
//   carga       in   pop request from CPU control (Rx loads entrada)
//   entrada     out  [LARGURA-1:0] head word, all zeros while empty
//   vazio       out  FIFO empty
//   cheio       out  FIFO full
//   contagem    out  [log2(PROFUNDIDADE):0] number of stored words
//   erro        out  sticky underflow flag (pop attempted while empty)
//
// Configuration
//   FILA_ENTRADA_ERRO_EN  when defined, `erro` latches any carga seen while
//                         empty and holds until reset; when undefined, `erro`
//                         is tied to 0 and no error logic exists.
// -----------------------------------------------------------------------------
module fila_entrada #(
   parameter int LARGURA      = 5,
   parameter int PROFUNDIDADE = 4
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic [LARGURA-1:0]                dado_in,
   input  logic                              dado_valid,
   output logic                              dado_ready,
   input  logic                              carga,
   output logic [LARGURA-1:0]                entrada,
   output logic                              vazio,
   output logic                              cheio,
   output logic [$clog2(PROFUNDIDADE):0]     contagem,
   output logic                              erro
);

   localparam int PTR_W = $clog2(PROFUNDIDADE);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PROFUNDIDADE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [LARGURA-1:0] mem [PROFUNDIDADE];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   logic push;
   logic pop;

   // Status flags come only from the registered count, so dado_ready never
   // depends on dado_valid or carga and no combinational path crosses the FIFO.
   assign vazio      = (count == '0);
   assign cheio      = (count == CNT_FULL);
   assign dado_ready = ~cheio;
   assign contagem   = count;

   // A carga on an empty FIFO is ignored, even if a word is being pushed on
   // the same edge: the new word only becomes poppable after it is stored.
   assign push = dado_valid & dado_ready;
   assign pop  = carga & ~vazio;

   // ---------------------------------------------------------------------------
   // Pointers and occupancy
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values of its neighbours, regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are exactly log2(PROFUNDIDADE) bits wide, so the natural
         // overflow of the increment is the wrap from PROFUNDIDADE-1 to 0.
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   // NOTE: the array has no reset on purpose; stale words are never visible
   // because entrada is masked while empty and a slot is always written
   // before the read pointer reaches it. This keeps it mappable to plain RAM.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= dado_in;
   end

   // ---------------------------------------------------------------------------
   // Head word (first-word fall-through)
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a value before any branch, so the
   // block can never hold a previous value and infer a latch.
   always_comb begin
      entrada = '0;
      if (!vazio) entrada = mem[rd_ptr];
   end

   // ---------------------------------------------------------------------------
   // Underflow flag
   // ---------------------------------------------------------------------------
`ifdef FILA_ENTRADA_ERRO_EN
   logic erro_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         erro_q <= 1'b0;
      end else if (carga && vazio) begin
         erro_q <= 1'b1;
      end
   end

   assign erro = erro_q;
`else
   assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_fila_entrada.sv
// -----------------------------------------------------------------------------
// tb_fila_entrada
//
// Directed bench for fila_entrada with default parameters (LARGURA=5,
// PROFUNDIDADE=4). Expected values are written by hand from the behaviour of
// the FIFO. Inputs change 1 time unit after each rising edge; outputs are
// sampled at that same point, when they are stable.
// -----------------------------------------------------------------------------
module tb_fila_entrada;

   localparam int LARGURA      = 5;
   localparam int PROFUNDIDADE = 4;
   localparam int CNT_W        = $clog2(PROFUNDIDADE) + 1;

`ifdef FILA_ENTRADA_ERRO_EN
   localparam bit ERRO_EN = 1'b1;
`else
   localparam bit ERRO_EN = 1'b0;
`endif

   logic               clock;
   logic               reset_n;
   logic [LARGURA-1:0] dado_in;
   logic               dado_valid;
   logic               dado_ready;
   logic               carga;
   logic [LARGURA-1:0] entrada;
   logic               vazio;
   logic               cheio;
   logic [CNT_W-1:0]   contagem;
   logic               erro;

   int total = 0;
   int bad   = 0;

   fila_entrada #(
      .LARGURA      (LARGURA),
      .PROFUNDIDADE (PROFUNDIDADE)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .dado_in    (dado_in),
      .dado_valid (dado_valid),
      .dado_ready (dado_ready),
      .carga      (carga),
      .entrada    (entrada),
      .vazio      (vazio),
      .cheio      (cheio),
      .contagem   (contagem),
      .erro       (erro)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle with the given inputs; returns 1 unit after the edge with
   // the inputs returned to idle.
   task automatic cyc(input logic v, input logic [LARGURA-1:0] d, input logic c);
      dado_valid = v;
      dado_in    = d;
      carga      = c;
      @(posedge clock);
      #1;
      dado_valid = 1'b0;
      dado_in    = '0;
      carga      = 1'b0;
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_vazio"},    vazio,    1);
      check({tag, "_contagem"}, contagem, 0);
      check({tag, "_entrada"},  entrada,  0);
   endtask

   logic [LARGURA-1:0] exp_q [$];

   initial begin
      reset_n    = 1'b0;
      dado_valid = 1'b0;
      dado_in    = '0;
      carga      = 1'b0;

      // ---------------- reset state ----------------
      #3;
      check_empty("rst");
      check("rst_cheio", cheio, 0);
      check("rst_ready", dado_ready, 1);
      check("rst_erro",  erro, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // ---------------- basic push / FWFT / pop ----------------
      cyc(1'b1, 5'h03, 1'b0);
      check("fwft_entrada", entrada, 5'h03);
      check("fwft_contagem", contagem, 1);
      cyc(1'b1, 5'h11, 1'b0);
      cyc(1'b1, 5'h1F, 1'b0);
      check("b3_contagem", contagem, 3);
      check("b3_entrada", entrada, 5'h03);
      check("b3_vazio", vazio, 0);
      cyc(1'b0, '0, 1'b1);
      check("pop1_entrada", entrada, 5'h11);
      check("pop1_contagem", contagem, 2);
      cyc(1'b0, '0, 1'b1);
      check("pop2_entrada", entrada, 5'h1F);
      cyc(1'b0, '0, 1'b1);
      check_empty("drain");

      // ---------------- full and back-pressure ----------------
      for (int i = 1; i <= 4; i++) cyc(1'b1, LARGURA'(i), 1'b0);
      check("full_cheio", cheio, 1);
      check("full_ready", dado_ready, 0);
      check("full_contagem", contagem, 4);
      cyc(1'b1, 5'h0A, 1'b0);
      check("full_block_contagem", contagem, 4);
      check("full_block_entrada", entrada, 5'h01);
      cyc(1'b1, 5'h0A, 1'b1);            // pop still happens, push blocked
      check("full_pop_contagem", contagem, 3);
      check("full_pop_entrada", entrada, 5'h02);
      check("full_pop_ready", dado_ready, 1);
      cyc(1'b1, 5'h0A, 1'b0);            // 0A enters now
      check("refill_contagem", contagem, 4);
      exp_q = '{5'h02, 5'h03, 5'h04, 5'h0A};
      foreach (exp_q[i]) begin
         check($sformatf("full_drain%0d", i), entrada, exp_q[i]);
         cyc(1'b0, '0, 1'b1);
      end
      check_empty("full_drain_end");

      // ---------------- streaming at depth 2 with wrap ----------------
      cyc(1'b1, 5'h10, 1'b0);
      cyc(1'b1, 5'h11, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("stream_head%0d", i), entrada, LARGURA'(5'h10 + i));
         cyc(1'b1, LARGURA'(5'h12 + i), 1'b1);
         check($sformatf("stream_cnt%0d", i), contagem, 2);
      end
      check("stream_tail0", entrada, 5'h1A);
      cyc(1'b0, '0, 1'b1);
      check("stream_tail1", entrada, 5'h1B);
      cyc(1'b0, '0, 1'b1);
      check_empty("stream_end");

      // ---------------- push + carga on empty ----------------
      cyc(1'b1, 5'h07, 1'b1);
      check("empty_pp_contagem", contagem, 1);
      check("empty_pp_entrada", entrada, 5'h07);
      check("empty_pp_erro", erro, 0);
      cyc(1'b0, '0, 1'b1);
      check_empty("empty_pp_pop");
      check("empty_pp_erro2", erro, 0);

      // ---------------- underflow ----------------
      cyc(1'b0, '0, 1'b1);
      check("uflow_erro", erro, ERRO_EN);
      check("uflow_contagem", contagem, 0);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b1, 5'h05, 1'b0);
      check("uflow_sticky", erro, ERRO_EN);
      check("uflow_push_entrada", entrada, 5'h05);
      cyc(1'b0, '0, 1'b1);

      // ---------------- asynchronous reset mid-operation ----------------
      cyc(1'b1, 5'h01, 1'b0);
      cyc(1'b1, 5'h02, 1'b0);
      cyc(1'b1, 5'h03, 1'b0);
      check("pre_arst_contagem", contagem, 3);
      #2;
      reset_n = 1'b0;
      #1;                                // still before the next edge
      check_empty("arst");
      check("arst_cheio", cheio, 0);
      check("arst_ready", dado_ready, 1);
      check("arst_erro", erro, 0);
      cyc(1'b1, 5'h09, 1'b1);            // push/pop under reset have no effect
      check_empty("arst_held");
      reset_n = 1'b1;
      cyc(1'b0, '0, 1'b0);
      check_empty("arst_release");
      cyc(1'b1, 5'h0C, 1'b0);
      check("post_arst_entrada", entrada, 5'h0C);
      check("post_arst_contagem", contagem, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fila_entrada.md
FILA_ENTRADA -- requirements
Module: fila_entrada

Interface
REQ-001 The parameter LARGURA SHALL default to 5 and set the data word width, which matches the CPU entrada bus.
REQ-002 The parameter PROFUNDIDADE SHALL default to 4 and set the number of words stored; legal values are powers of two from 2 to 16.
REQ-003 The port clock SHALL be an input, 1 bit wide, and serve as the single clock; all state updates on its rising edge.
REQ-004 The port reset_n SHALL be an input, 1 bit wide, and act as the asynchronous, active-low reset.
REQ-005 The port dado_in SHALL be an input, LARGURA bits wide, and carry the word offered by the external source.
REQ-006 The port dado_valid SHALL be an input, 1 bit wide, and mean that the source offers dado_in this cycle.
REQ-007 The port dado_ready SHALL be an output, 1 bit wide, and mean that the FIFO accepts a word this cycle.
REQ-008 The port carga SHALL be an input, 1 bit wide, and be driven by the CPU control; it means that Rx loads entrada at this edge (pop request).
REQ-009 The port entrada SHALL be an output, LARGURA bits wide, and carry the head word that feeds the CPU Rx register.
REQ-010 The port vazio SHALL be an output, 1 bit wide, and mean that the FIFO is empty.
REQ-011 The port cheio SHALL be an output, 1 bit wide, and mean that the FIFO is full.
REQ-012 The port contagem SHALL be an output, log2(PROFUNDIDADE)+1 bits wide, and give the current number of stored words.
REQ-013 The port erro SHALL be an output, 1 bit wide, and be a sticky underflow flag (see Configuration).

Function
REQ-014 A push SHALL occur on a rising edge exactly when dado_valid=1 and dado_ready=1.
REQ-015 dado_ready SHALL equal NOT cheio, combinationally from registered state only, with no dependence on dado_valid or carga.
REQ-016 A pop SHALL occur on a rising edge exactly when carga=1 and vazio=0; a carga with vazio=1 SHALL leave state unchanged.
REQ-017 entrada SHALL present the oldest stored word in first-word-fall-through mode: a word pushed at edge N is visible on entrada immediately after edge N if the FIFO was empty.
REQ-018 When vazio=1, entrada SHALL be all zeros.
REQ-019 Storage SHALL be a circular buffer with write and read pointers of log2(PROFUNDIDADE) bits that wrap from PROFUNDIDADE-1 to 0.
REQ-020 contagem SHALL update as follows on each edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-021 vazio SHALL be 1 exactly when contagem=0, and cheio SHALL be 1 exactly when contagem=PROFUNDIDADE.
REQ-022 On simultaneous push and pop with 0<contagem<PROFUNDIDADE, both pointers SHALL advance, contagem SHALL hold, and the popped word SHALL be the old head.
REQ-023 When full, a push SHALL be impossible because dado_ready=0, and a pop in that cycle SHALL still occur.
REQ-024 When empty, a push SHALL proceed and a coincident carga SHALL be ignored; the new word is not consumed in that cycle.
REQ-025 No word SHALL be lost, duplicated or reordered for any legal push/pop sequence.

Reset
REQ-026 reset_n=0 SHALL immediately, without waiting for clock, clear both pointers, contagem=0, vazio=1, cheio=0, dado_ready=1, entrada=0 and erro=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored words, and a push or pop in that cycle SHALL have no effect.
REQ-028 Storage array contents SHALL NOT require reset; they are masked by vazio.

Configuration
REQ-029 With macro FILA_ENTRADA_ERRO_EN defined, erro SHALL set to 1 on any edge where carga=1 and vazio=1, and hold until reset_n=0.
REQ-030 Without FILA_ENTRADA_ERRO_EN, erro SHALL be constant 0, no error logic SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then push 5'h03, 5'h11, 5'h1F -> entrada=03 after the first edge; contagem=3; pops then yield 03, 11, 1F; vazio=1 and entrada=0 afterwards.
REQ-032 Push 4 words with PROFUNDIDADE=4 -> cheio=1 and dado_ready=0; a 5th word 5'h0A held valid is not accepted; one pop then lets 0A enter on the next edge.
REQ-033 Hold a steady push and pop stream at contagem=2 for 10 cycles -> contagem stays 2, pointers wrap, and the output order equals the input order.
REQ-034 On an empty FIFO, assert carga and dado_valid with 5'h07 in the same cycle -> contagem=1 and entrada=07; erro=0 under FILA_ENTRADA_ERRO_EN.
REQ-035 On an empty FIFO, assert carga alone -> erro=1 and sticky with FILA_ENTRADA_ERRO_EN, erro=0 without it; contagem stays 0.
REQ-036 At contagem=3, drop reset_n between clock edges -> vazio=1, contagem=0 and entrada=0 before the next edge.
